// File: rtl/tensor_core_pkg.sv
// Shared types and sizing for the tensor core sequencer.
package tensor_core_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned MATRIX_DIM         = 4;
    localparam int unsigned NUM_ELEMENTS       = MATRIX_DIM * MATRIX_DIM;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] element_t;
    typedef element_t [MATRIX_DIM-1:0][MATRIX_DIM-1:0] matrix_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        START,
        WAIT,
        CAPTURE,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/tensor_core_sequencer.sv
// Streams two 4x4 operands into the tensor core, runs it, and streams the 16 results back out.
module tensor_core_sequencer
    import tensor_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic                                                   clock_in,
    input  logic                                                   reset_in,
    input  logic signed [DATA_WIDTH-1:0]                           in_data,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    output logic signed [DATA_WIDTH-1:0]                           out_data,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic                                                   out_last,
    output logic                                                   busy,
    output logic                                                   timeout_error,
    output logic                                                   tensor_core_register_file_write_enable,
    output logic                                                   should_start_tensor_core,
    output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] tensor_core_input1,
    output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] tensor_core_input2,
    input  logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] tensor_core_output,
    input  logic                                                   is_done_with_calculation
);

    localparam int unsigned WAIT_CNT_W = $clog2(WAIT_LIMIT + 1);

    seq_state_t                                             r_state;
    seq_state_t                                             w_state_next;
    logic [4:0]                                             r_load_idx;
    logic [WAIT_CNT_W-1:0]                                  r_wait_cnt;
    logic [WAIT_CNT_W-1:0]                                  w_wait_inc;
    logic [3:0]                                             r_drain_idx;
    logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0]  r_a;
    logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0]  r_b;
    logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0]  r_result;
    logic                                                   r_timeout;
    logic                                                   w_timeout_hit;
    logic                                                   w_in_fire;
    logic                                                   w_out_fire;

    assign w_in_fire          = in_valid && in_ready;
    assign w_out_fire         = out_valid && out_ready;
    assign w_wait_inc         = r_wait_cnt + 1'b1;
    assign timeout_error      = r_timeout;
    assign tensor_core_input1 = r_a;
    assign tensor_core_input2 = r_b;

    always_comb begin
        w_state_next                           = r_state;
        w_timeout_hit                          = 1'b0;
        in_ready                               = 1'b0;
        out_valid                              = 1'b0;
        out_data                               = '0;
        out_last                               = 1'b0;
        busy                                   = (r_state != IDLE);
        tensor_core_register_file_write_enable = 1'b0;
        should_start_tensor_core               = 1'b0;
        case (r_state)
            IDLE: begin
                // Held low while reset is asserted so nothing is accepted during reset.
                in_ready = !reset_in;
                if (in_valid && !reset_in) w_state_next = LOAD;
            end
            LOAD: begin
                in_ready = !reset_in;
                if (in_valid && r_load_idx == 5'(2 * NUM_ELEMENTS - 1)) w_state_next = CLEAR;
            end
            CLEAR: begin
                tensor_core_register_file_write_enable = 1'b1;
                w_state_next                           = START;
            end
            START: begin
                should_start_tensor_core = 1'b1;
                w_state_next             = WAIT;
            end
            WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (is_done_with_calculation) begin
                    w_state_next = CAPTURE;
                end else if (w_wait_inc == WAIT_CNT_W'(WAIT_LIMIT)) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = IDLE;
                end
            end
            CAPTURE: w_state_next = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = r_result[r_drain_idx[3:2]][r_drain_idx[1:0]];
                out_last  = (r_drain_idx == 4'(NUM_ELEMENTS - 1));
                if (out_ready && out_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= IDLE;
            r_load_idx  <= '0;
            r_wait_cnt  <= '0;
            r_drain_idx <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_in_fire) begin
                // Index bit 4 selects B; the low bits give row-major position.
                if (r_load_idx[4]) r_b[r_load_idx[3:2]][r_load_idx[1:0]] <= in_data;
                else               r_a[r_load_idx[3:2]][r_load_idx[1:0]] <= in_data;
                r_load_idx <= r_load_idx + 5'd1;
                if (r_state == IDLE) r_timeout <= 1'b0;
            end
            if (r_state == START)     r_wait_cnt <= '0;
            else if (r_state == WAIT) r_wait_cnt <= w_wait_inc;
            if (w_timeout_hit) r_timeout <= 1'b1;
            if (r_state == CAPTURE) begin
                r_result    <= tensor_core_output;
                r_drain_idx <= '0;
            end else if (w_out_fire) begin
                r_drain_idx <= r_drain_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Self-checking bench: fixed job table, corner-case sequences and random jobs against a matmul model.
module tb_tensor_core_sequencer;

    localparam int DW       = 8;
    localparam int WL       = 64;
    localparam int CORE_LAT = 9;

    logic                          clock_in;
    logic                          reset_in;
    logic signed [DW-1:0]          in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DW-1:0]          out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic                          busy;
    logic                          timeout_error;
    logic                          we;
    logic                          ss;
    logic [3:0][3:0][DW-1:0]       in1;
    logic [3:0][3:0][DW-1:0]       in2;
    logic [3:0][3:0][DW-1:0]       core_out;
    logic                          core_done;
    logic                          core_en;
    int                            core_cnt;

    int total = 0;
    int bad   = 0;
    int ja[16];
    int jb[16];
    int exp_q[16];
    int cyc = 0, we_cnt = 0, ss_cnt = 0, we_cyc = 0, ss_cyc = 0;

    typedef struct packed {
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        logic [15:0][7:0] e;
    } vec_t;
    vec_t vecs[3];

    tensor_core_sequencer #(.DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .clock_in                               (clock_in),
        .reset_in                               (reset_in),
        .in_data                                (in_data),
        .in_valid                               (in_valid),
        .in_ready                               (in_ready),
        .out_data                               (out_data),
        .out_valid                              (out_valid),
        .out_ready                              (out_ready),
        .out_last                               (out_last),
        .busy                                   (busy),
        .timeout_error                          (timeout_error),
        .tensor_core_register_file_write_enable (we),
        .should_start_tensor_core               (ss),
        .tensor_core_input1                     (in1),
        .tensor_core_input2                     (in2),
        .tensor_core_output                     (core_out),
        .is_done_with_calculation               (core_done)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0][3:0][DW-1:0] core_mm(input logic [3:0][3:0][DW-1:0] a,
                                                        input logic [3:0][3:0][DW-1:0] b);
        logic [3:0][3:0][DW-1:0] r;
        int s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += int'($signed(a[i][k])) * int'($signed(b[k][j]));
                r[i][j] = s[DW-1:0];
            end
        end
        return r;
    endfunction

    // Behavioural stand-in for small_tensor_core; core_en=0 makes it never finish.
    always @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            core_done <= 1'b0;
            core_out  <= '0;
            core_cnt  <= 0;
        end else begin
            if (we) begin
                core_done <= 1'b0;
                core_out  <= '0;
            end
            if (ss && core_en) begin
                core_cnt <= CORE_LAT;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    core_done <= 1'b1;
                    core_out  <= core_mm(in1, in2);
                end
            end
        end
    end

    always @(negedge clock_in) begin
        cyc <= cyc + 1;
        if (we) begin we_cnt <= we_cnt + 1; we_cyc <= cyc; end
        if (ss) begin ss_cnt <= ss_cnt + 1; ss_cyc <= cyc; end
    end

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic void ref_model();
        int s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += ja[r * 4 + k] * jb[k * 4 + c];
                s = ((s % 256) + 256) % 256;
                if (s >= 128) s -= 256;
                exp_q[r * 4 + c] = s;
            end
        end
    endfunction

    task automatic send_elem(input int v, input bit rnd);
        int guard = 0;
        @(negedge clock_in);
        if (rnd) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clock_in);
        end
        in_valid = 1'b1;
        in_data  = v[DW-1:0];
        while (!in_ready && guard < 300) begin
            @(negedge clock_in);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clock_in);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_job(input int from, input bit rnd);
        for (int i = from; i < 32; i++) send_elem((i < 16) ? ja[i] : jb[i - 16], rnd);
    endtask

    task automatic drain_check(input int stall_at, input int stall_len, input bit rnd);
        int   idx = 0, guard = 0, stalled = 0;
        bit   pend = 1'b0;
        bit   r;
        int   hd;
        int   hl;
        while (idx < 16 && guard < 3000) begin
            @(negedge clock_in);
            guard++;
            if (pend) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), hd);
                check("hold_last", int'(out_last), hl);
            end
            pend = 1'b0;
            if (out_valid) begin
                r = 1'b1;
                if (idx == stall_at && stalled < stall_len) begin
                    r = 1'b0;
                    stalled++;
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    r = 1'b0;
                end
                if (r) begin
                    check($sformatf("data[%0d]", idx), int'(out_data), exp_q[idx]);
                    check($sformatf("last[%0d]", idx), int'(out_last), int'(idx == 15));
                    idx++;
                end else begin
                    pend = 1'b1;
                    hd   = int'(out_data);
                    hl   = int'(out_last);
                end
                out_ready = r;
            end else begin
                out_ready = 1'b0;
            end
        end
        if (idx < 16) check("drain_timeout", idx, 16);
        @(negedge clock_in);
        out_ready = 1'b0;
        check("busy_after_drain", int'(busy), 0);
        check("valid_after_drain", int'(out_valid), 0);
    endtask

    task automatic run_job(input bit rnd, input int stall_at, input int stall_len);
        int we0 = we_cnt;
        int ss0 = ss_cnt;
        send_job(0, rnd);
        drain_check(stall_at, stall_len, rnd);
        check("we_pulses", we_cnt - we0, 1);
        check("ss_pulses", ss_cnt - ss0, 1);
        check("ss_after_we", ss_cyc - we_cyc, 1);
    endtask

    task automatic load_vec(input int v);
        logic signed [7:0] t;
        for (int i = 0; i < 16; i++) begin
            t = vecs[v].a[i]; ja[i] = t;
            t = vecs[v].b[i]; jb[i] = t;
            t = vecs[v].e[i]; exp_q[i] = t;
        end
    endtask

    initial begin
        int guard;
        bit ok;

        for (int i = 0; i < 16; i++) begin
            vecs[0].a[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
            vecs[0].b[i] = 8'(i + 1);
            vecs[0].e[i] = 8'(i + 1);
            vecs[1].a[i] = 8'd2;
            vecs[1].b[i] = 8'd3;
            vecs[1].e[i] = 8'd24;
            vecs[2].a[i] = 8'd16;
            vecs[2].b[i] = 8'd2;
            vecs[2].e[i] = 8'h80;
        end

        reset_in  = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        core_en   = 1'b1;
        repeat (3) @(negedge clock_in);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout", int'(timeout_error), 0);
        check("rst_we", int'(we), 0);
        check("rst_ss", int'(ss), 0);
        reset_in = 1'b0;
        @(negedge clock_in);
        check("idle_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            run_job(1'b0, -1, 0);
        end

        // Back-pressure at element 3.
        load_vec(0);
        run_job(1'b0, 3, 5);

        // Timeout: core never completes.
        core_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ja[i] = int'($urandom_range(0, 255)) - 128;
            jb[i] = int'($urandom_range(0, 255)) - 128;
        end
        send_job(0, 1'b0);
        guard = 0;
        do begin
            @(negedge clock_in);
            guard++;
        end while (!ss && guard < 20);
        check("timeout_start_seen", int'(ss), 1);
        ok = 1'b1;
        for (int n = 0; n < WL; n++) begin
            @(negedge clock_in);
            if (timeout_error || !busy) ok = 1'b0;
        end
        check("wait_busy_64", int'(ok), 1);
        @(negedge clock_in);
        check("timeout_flag", int'(timeout_error), 1);
        check("timeout_in_ready", int'(in_ready), 1);
        check("timeout_busy", int'(busy), 0);
        core_en = 1'b1;
        send_elem(ja[0], 1'b0);
        check("timeout_cleared", int'(timeout_error), 0);
        send_job(1, 1'b0);
        ref_model();
        drain_check(-1, 0, 1'b0);

        // Reset mid-LOAD after 20 elements.
        for (int i = 0; i < 16; i++) begin
            ja[i] = int'($urandom_range(1, 255)) - 128;
            jb[i] = int'($urandom_range(1, 255)) - 128;
        end
        for (int i = 0; i < 20; i++) send_elem((i < 16) ? ja[i] : jb[i - 16], 1'b0);
        @(negedge clock_in);
        #2;
        reset_in = 1'b1;
        #1;
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_a_clear", int'(in1 != '0), 0);
        check("midrst_b_clear", int'(in2 != '0), 0);
        @(negedge clock_in);
        reset_in = 1'b0;
        load_vec(0);
        run_job(1'b0, -1, 0);

        // Random jobs with random input gaps and output back-pressure.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 16; i++) begin
                ja[i] = int'($urandom_range(0, 255)) - 128;
                jb[i] = int'($urandom_range(0, 255)) - 128;
            end
            ref_model();
            run_job(1'b1, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tensor_core_sequencer.md
Name: tensor_core_sequencer

Overview:
Initiator-side controller for small_tensor_core. It accepts a byte stream of two signed 4x4 operand matrices, clears and starts the core, then waits for completion. It captures the 16 results and streams them back out over a valid/ready interface. It sits between the host/register-file datapath and the tensor core, and owns every core control input.

Parameters:
DATA_WIDTH, 8, element width in bits; signed two's complement.
WAIT_LIMIT, 64, maximum cycles in WAIT before timeout.

Ports:
clock_in  input  1  system clock; all logic is posedge-only
reset_in  input  1  asynchronous, active-high reset
in_data  input  DATA_WIDTH  signed operand element
in_valid  input  1  in_data valid
in_ready  output  1  sequencer accepts in_data this cycle
out_data  output  DATA_WIDTH  signed result element
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  marks result element 15
busy  output  1  high in every state except IDLE
timeout_error  output  1  last job timed out
tensor_core_register_file_write_enable  output  1  core clear/load strobe
should_start_tensor_core  output  1  core start request
tensor_core_input1  output  [4][4] x DATA_WIDTH  matrix A
tensor_core_input2  output  [4][4] x DATA_WIDTH  matrix B
tensor_core_output  input  [4][4] x DATA_WIDTH  core result array
is_done_with_calculation  input  1  core completion flag

Behaviour:
- Reset (async, reset_in=1): state=IDLE; all operand and result buffers, counters = 0; in_ready=0, out_valid=0, out_last=0, busy=0, timeout_error=0, write_enable=0, should_start=0. Reset asserted mid-job aborts the job immediately, with no drain.
- in_ready=1 only in IDLE and LOAD.
- IDLE: the first handshake (in_valid&&in_ready) stores element 0 and moves to LOAD. That handshake also clears timeout_error.
- LOAD: load_idx counts 0..31.
  - Elements 0-15 are A, row-major: A[idx/4][idx%4].
  - Elements 16-31 are B, row-major.
  - No handshake = hold.
  - Accepting element 31 moves to CLEAR.
- CLEAR: write_enable=1 for exactly one cycle; then go to START.
- START: should_start=1 for exactly one cycle; wait counter reset; then go to WAIT.
- WAIT:
  - Wait counter increments each cycle.
  - If is_done_with_calculation=1, go to CAPTURE. Done has priority over a same-cycle timeout.
  - If the counter reaches WAIT_LIMIT, set timeout_error=1 and go to IDLE.
- CAPTURE: register all 16 tensor_core_output elements into the result buffer in one cycle; drain_idx=0; go to DRAIN.
- DRAIN:
  - out_valid=1; out_data=result[drain_idx/4][drain_idx%4].
  - out_last=(drain_idx==15).
  - On out_valid&&out_ready, drain_idx++.
  - Handshake at index 15 goes to IDLE.
  - out_data/out_last must stay stable while out_valid=1 and out_ready=0.
- Operand outputs hold their values from CLEAR through DRAIN. They are updated only by LOAD handshakes.
- Arithmetic: the sequencer does none. Results are whatever the core produces at DATA_WIDTH, wrapped modulo 2^DATA_WIDTH.
- Latency: 32 input handshakes → CLEAR(1) → START(1) → WAIT(core, ≈9 posedges) → CAPTURE(1) → first out_valid.
- Back-to-back jobs: a new job is accepted only after the last DRAIN handshake, i.e. once back in IDLE.

Decomposition:
- tensor_core_pkg holds:
  - DATA_WIDTH default, MATRIX_DIM=4, NUM_ELEMENTS=16
  - typedef element_t (logic signed [DATA_WIDTH-1:0])
  - typedef matrix_t (element_t [4][4])
  - enum seq_state_t {IDLE, LOAD, CLEAR, START, WAIT, CAPTURE, DRAIN}
- Single module, no sub-module required. The FSM, load counter (5b), wait counter ($clog2(WAIT_LIMIT+1)b) and drain counter (4b) all live in one always_ff plus one output always_comb.

Test Plan:
- A=identity, B=1..16 row-major, core model attached, out_ready=1 → out_data 1,2,…,16 in order; out_last only on 16; busy falls after the last handshake.
- A all 2, B all 3 → 16 outputs of 24; write_enable and should_start each observed high for exactly one cycle, in that order.
- A all 16, B all 2 (8-bit wrap) → every output = -128 (0x80).
- Back-pressure: out_ready=0 for 5 cycles at drain_idx=3 → out_data/out_last/out_valid held constant; sequence resumes 4..16 unchanged with no duplicates.
- Timeout: stub core never asserts done → exactly WAIT_LIMIT=64 cycles after START, timeout_error=1, state IDLE, in_ready=1. The next accepted element clears timeout_error.
- Reset mid-LOAD after 20 elements, then a full new job (A=identity, B=1..16) → no stale data; outputs 1..16.
